bus_trace_monitor: RTL and testbench

//  Passive, synthesizable monitor for the 8085-style system bus (S0/S1/IOMn/RDn/WRn/ALE).
//  - Decodes each machine cycle.
//  - Captures {type, address, data, timestamp} into a trace FIFO and keeps per-type cycle counters.
//  - Sits beside the CPU in `system`; trace is drained by a bench or debug port over valid/ready.
//  - Generalises the bench's data-bus print loop: parametrised widths/depth, overflow mode, error detection.

---
 rtl/bus_trace_pkg.sv | 46 ++++
 rtl/bus_trace_monitor_if.sv | 39 +++
 rtl/bus_trace_monitor_fifo.sv | 70 +++++++
 rtl/bus_trace_monitor.sv | 164 ++++++++++++++++
 tb/tb_bus_trace_monitor.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_trace_pkg.sv
// ============================================================================
// bus_trace_pkg : cycle/state types and status decode for the bus trace monitor
// Rev 1.0
// ============================================================================
`default_nettype none

package bus_trace_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        MEMRD = 3'd1,
        MEMWR = 3'd2,
        IORD  = 3'd3,
        IOWR  = 3'd4,
        INTA  = 3'd5,
        HALT  = 3'd6,
        NONE  = 3'd7
    } cyc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        STRB = 2'd2
    } state_t;

    // NONE flags an illegal status code, including I/O with S1S0=00.
    function automatic cyc_t decode_status(input logic iomn, input logic s1, input logic s0);
        case ({iomn, s1, s0})
            3'b011:  return FETCH;
            3'b010:  return MEMRD;
            3'b001:  return MEMWR;
            3'b110:  return IORD;
            3'b101:  return IOWR;
            3'b111:  return INTA;
            3'b000:  return HALT;
            default: return NONE;
        endcase
    endfunction

    function automatic logic is_read(input cyc_t t);
        return (t == FETCH) || (t == MEMRD) || (t == IORD) || (t == INTA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_trace_monitor_if.sv
// ============================================================================
// bus_trace_monitor_if : 8085-style bus signals plus trace valid/ready stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface bus_trace_monitor_if #(
    parameter int AW  = 16,
    parameter int DW  = 8,
    parameter int TSW = 16
) ();
    logic           S0;
    logic           S1;
    logic           IOMn;
    logic           RDn;
    logic           WRn;
    logic           ALE;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;

    logic           tr_valid;
    logic           tr_ready;
    logic [2:0]     tr_type;
    logic [AW-1:0]  tr_addr;
    logic [DW-1:0]  tr_data;
    logic [TSW-1:0] tr_ts;

    modport master (
        output S0, S1, IOMn, RDn, WRn, ALE, addr, data, tr_ready,
        input  tr_valid, tr_type, tr_addr, tr_data, tr_ts
    );

    modport slave (
        input  S0, S1, IOMn, RDn, WRn, ALE, addr, data, tr_ready,
        output tr_valid, tr_type, tr_addr, tr_data, tr_ts
    );
endinterface

`default_nettype wire

// File: rtl/bus_trace_monitor_fifo.sv
// ============================================================================
// trace_fifo : single-clock record FIFO with drop-new or overwrite-oldest on full
// Rev 1.0
// ============================================================================
`default_nettype none

module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rstn,
    input  wire logic                     clr_i,
    input  wire logic                     push_i,
    input  wire logic [W-1:0]             wdata_i,
    input  wire logic                     pop_i,
    input  wire logic                     ovw_i,
    output logic      [W-1:0]             rdata_o,
    output logic                          empty_o,
    output logic      [$clog2(DEPTH):0]   level_o,
    output logic                          drop_o
);
    localparam int              PW     = $clog2(DEPTH);
    localparam logic [PW:0]     C_FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [PW:0]   cnt_q;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_adv_rd;

    assign empty_o = (cnt_q == '0);
    assign w_full  = (cnt_q == C_FULL);
    assign level_o = cnt_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

    // Overwrite on full writes into the oldest slot and advances the read pointer past it.
    always_comb begin
        w_pop    = !clr_i && pop_i && !empty_o;
        w_wr     = !clr_i && push_i && (!w_full || w_pop || ovw_i);
        w_adv_rd = w_pop || (!clr_i && push_i && w_full && !w_pop && ovw_i);
        drop_o   = !clr_i && push_i && w_full && !w_pop;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (w_wr)     wr_q <= wr_q + 1'b1;
            if (w_adv_rd) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(w_wr) - (PW+1)'(w_adv_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_q] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/bus_trace_monitor.sv
// ============================================================================
// bus_trace_monitor : passive 8085 bus cycle decoder, tracer and cycle counter
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_trace_monitor
    import bus_trace_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int TSW   = 16,
    parameter int CNTW  = 16
) (
    input  wire logic                    clk,
    input  wire logic                    rstn,
    input  wire logic                    en,
    input  wire logic                    mode_ovw,
    input  wire logic                    clr,
    bus_trace_monitor_if.slave           bus,
    output logic      [$clog2(DEPTH):0]  level,
    output logic                         ovf,
    output logic                         err,
    input  wire logic [2:0]              cnt_sel,
    output logic      [CNTW-1:0]         cnt_val
);
    localparam int RW = 3 + AW + DW + TSW;

    state_t          state_q, state_d;
    cyc_t            type_q, type_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [TSW-1:0]  ts_q;
    logic            err_q, ovf_q;
    logic [CNTW-1:0] cnt_q [8];

    cyc_t            w_dec;
    logic            w_strb_low;
    logic            w_push;
    cyc_t            w_push_type;
    logic [AW-1:0]   w_push_addr;
    logic [DW-1:0]   w_push_data;
    logic            w_set_err;
    logic            w_drop;
    logic            w_empty;
    logic [RW-1:0]   w_rdata;

    assign w_dec      = decode_status(bus.IOMn, bus.S1, bus.S0);
    assign w_strb_low = is_read(type_q) ? !bus.RDn : !bus.WRn;

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        addr_d      = addr_q;
        data_d      = data_q;
        w_push      = 1'b0;
        w_push_type = type_q;
        w_push_addr = addr_q;
        w_push_data = data_q;
        w_set_err   = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            if (!bus.RDn && !bus.WRn) w_set_err = 1'b1;
            if (bus.ALE) begin
                // ALE outside IDLE aborts the cycle in flight; the new cycle is latched anyway.
                if (state_q != IDLE) w_set_err = 1'b1;
                if (w_dec == NONE) begin
                    w_set_err = 1'b1;
                    state_d   = IDLE;
                end else if (w_dec == HALT) begin
                    w_push      = 1'b1;
                    w_push_type = HALT;
                    w_push_addr = bus.addr;
                    w_push_data = '0;
                    state_d     = IDLE;
                end else begin
                    type_d  = w_dec;
                    addr_d  = bus.addr;
                    state_d = ADDR;
                end
            end else begin
                case (state_q)
                    ADDR: begin
                        if (w_strb_low) begin
                            data_d  = bus.data;
                            state_d = STRB;
                        end
                    end
                    STRB: begin
                        if (w_strb_low) begin
                            data_d = bus.data;
                        end else begin
                            w_push  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            type_q  <= FETCH;
            addr_q  <= '0;
            data_q  <= '0;
            ts_q    <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ts_q    <= ts_q + 1'b1;
            if (clr) begin
                err_q <= 1'b0;
                ovf_q <= 1'b0;
                for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
            end else begin
                if (w_set_err) err_q <= 1'b1;
                if (w_drop)    ovf_q <= 1'b1;
                for (int i = 0; i < 8; i++) begin
                    if (w_push && (w_push_type == cyc_t'(i)) && (cnt_q[i] != '1))
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    trace_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (clr),
        .push_i  (w_push),
        .wdata_i ({w_push_type, w_push_addr, w_push_data, ts_q}),
        .pop_i   (bus.tr_ready),
        .ovw_i   (mode_ovw),
        .rdata_o (w_rdata),
        .empty_o (w_empty),
        .level_o (level),
        .drop_o  (w_drop)
    );

    assign bus.tr_valid = !w_empty;
    assign bus.tr_type  = w_rdata[RW-1 -: 3];
    assign bus.tr_addr  = w_rdata[TSW+DW +: AW];
    assign bus.tr_data  = w_rdata[TSW +: DW];
    assign bus.tr_ts    = w_rdata[TSW-1:0];
    assign ovf          = ovf_q;
    assign err          = err_q;
    assign cnt_val      = cnt_q[cnt_sel];

endmodule

`default_nettype wire

// File: tb/tb_bus_trace_monitor.sv
// ============================================================================
// tb_bus_trace_monitor : directed checks of the bus trace monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_trace_monitor;
    localparam logic [2:0] C_FETCH = 3'b011;
    localparam logic [2:0] C_MEMRD = 3'b010;
    localparam logic [2:0] C_IOWR  = 3'b101;
    localparam logic [2:0] C_HALT  = 3'b000;
    localparam logic [2:0] C_BAD   = 3'b100;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b1;
    logic        mode_ovw = 1'b0;
    logic        clr = 1'b0;
    logic [2:0]  cs0 = 3'd0;
    logic [2:0]  cs1 = 3'd0;
    logic [4:0]  level0, level1;
    logic        ovf0, ovf1, err0, err1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] ts_a;

    always #5 clk = ~clk;

    bus_trace_monitor_if #(.AW(16), .DW(8), .TSW(16)) bi0 ();
    bus_trace_monitor_if #(.AW(16), .DW(8), .TSW(16)) bi1 ();

    assign bi1.S0       = bi0.S0;
    assign bi1.S1       = bi0.S1;
    assign bi1.IOMn     = bi0.IOMn;
    assign bi1.RDn      = bi0.RDn;
    assign bi1.WRn      = bi0.WRn;
    assign bi1.ALE      = bi0.ALE;
    assign bi1.addr     = bi0.addr;
    assign bi1.data     = bi0.data;
    assign bi1.tr_ready = 1'b1;

    bus_trace_monitor #(.AW(16), .DW(8), .DEPTH(16), .TSW(16), .CNTW(16)) u_dut (
        .clk(clk), .rstn(rstn), .en(en), .mode_ovw(mode_ovw), .clr(clr),
        .bus(bi0), .level(level0), .ovf(ovf0), .err(err0),
        .cnt_sel(cs0), .cnt_val(cnt0)
    );

    bus_trace_monitor #(.AW(16), .DW(8), .DEPTH(16), .TSW(16), .CNTW(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .en(en), .mode_ovw(mode_ovw), .clr(clr),
        .bus(bi1), .level(level1), .ovf(ovf1), .err(err1),
        .cnt_sel(cs1), .cnt_val(cnt1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete machine cycle; strobe held low for nlow clocks, data bus cleared at strobe end.
    task automatic bus_cycle(input logic [2:0] code, input logic [15:0] a,
                             input logic [7:0] d, input int nlow, input logic pop_last);
        bi0.ALE = 1'b1;
        {bi0.IOMn, bi0.S1, bi0.S0} = code;
        bi0.addr = a;
        tick();
        bi0.ALE  = 1'b0;
        bi0.data = d;
        if (code[1:0] == 2'b01) bi0.WRn = 1'b0;
        else                    bi0.RDn = 1'b0;
        repeat (nlow) tick();
        bi0.RDn      = 1'b1;
        bi0.WRn      = 1'b1;
        bi0.data     = 8'h00;
        bi0.tr_ready = pop_last;
        tick();
        bi0.tr_ready = 1'b0;
    endtask

    task automatic pop_one();
        bi0.tr_ready = 1'b1;
        tick();
        bi0.tr_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bi0.S0 = 1'b0; bi0.S1 = 1'b0; bi0.IOMn = 1'b0;
        bi0.RDn = 1'b1; bi0.WRn = 1'b1; bi0.ALE = 1'b0;
        bi0.addr = '0; bi0.data = '0; bi0.tr_ready = 1'b0;
        #12;
        check_eq("rst_valid", bi0.tr_valid, 0);
        check_eq("rst_level", level0, 0);
        check_eq("rst_ovf", ovf0, 0);
        check_eq("rst_err", err0, 0);
        check_eq("rst_type", bi0.tr_type, 0);
        check_eq("rst_cnt", cnt0, 0);
        rstn = 1'b1;
        tick();

        // Fetch with 2-clock read strobe
        bus_cycle(C_FETCH, 16'h0040, 8'h3E, 2, 1'b0);
        check_eq("f_valid", bi0.tr_valid, 1);
        check_eq("f_type", bi0.tr_type, 0);
        check_eq("f_addr", bi0.tr_addr, 16'h0040);
        check_eq("f_data", bi0.tr_data, 8'h3E);
        cs0 = 3'd0; #1;
        check_eq("f_cnt", cnt0, 1);
        pop_one();
        check_eq("f_drained", bi0.tr_valid, 0);

        // IO write followed immediately by HALT
        bus_cycle(C_IOWR, 16'h00F1, 8'hA5, 1, 1'b0);
        bi0.ALE = 1'b1;
        {bi0.IOMn, bi0.S1, bi0.S0} = C_HALT;
        bi0.addr = 16'h1234;
        tick();
        bi0.ALE = 1'b0;
        check_eq("w_level", level0, 2);
        check_eq("w_type", bi0.tr_type, 4);
        check_eq("w_addr", bi0.tr_addr, 16'h00F1);
        check_eq("w_data", bi0.tr_data, 8'hA5);
        ts_a = bi0.tr_ts;
        pop_one();
        check_eq("h_type", bi0.tr_type, 6);
        check_eq("h_addr", bi0.tr_addr, 16'h1234);
        check_eq("h_data", bi0.tr_data, 0);
        check_eq("h_ts", bi0.tr_ts, ts_a + 16'd1);
        pop_one();
        check_eq("e_level", level0, 0);
        check_eq("e_addr", bi0.tr_addr, 0);

        // 17 reads into a 16-deep FIFO, drop mode
        for (int i = 1; i <= 17; i++) bus_cycle(C_MEMRD, 16'h0100 + 16'(i), 8'(i), 1, 1'b0);
        check_eq("d_level", level0, 16);
        check_eq("d_ovf", ovf0, 1);
        check_eq("d_head", bi0.tr_addr, 16'h0101);
        cs0 = 3'd1; #1;
        check_eq("d_cnt", cnt0, 17);
        pulse_clr();
        check_eq("c_level", level0, 0);
        check_eq("c_ovf", ovf0, 0);
        check_eq("c_cnt", cnt0, 0);

        // Same in overwrite mode
        mode_ovw = 1'b1;
        for (int i = 1; i <= 17; i++) bus_cycle(C_MEMRD, 16'h0100 + 16'(i), 8'(i), 1, 1'b0);
        check_eq("o_level", level0, 16);
        check_eq("o_ovf", ovf0, 1);
        check_eq("o_head", bi0.tr_addr, 16'h0102);
        check_eq("o_data", bi0.tr_data, 8'h02);
        mode_ovw = 1'b0;
        pulse_clr();

        // Full with a simultaneous pop: no loss, order kept
        for (int i = 1; i <= 16; i++) bus_cycle(C_MEMRD, 16'h0200 + 16'(i), 8'(i), 1, 1'b0);
        check_eq("p_full", level0, 16);
        bus_cycle(C_MEMRD, 16'h0211, 8'h11, 1, 1'b1);
        check_eq("p_level", level0, 16);
        check_eq("p_ovf", ovf0, 0);
        for (int i = 2; i <= 17; i++) begin
            check_eq("p_order", bi0.tr_addr, 16'h0200 + 16'(i));
            pop_one();
        end
        pop_one();
        check_eq("p_empty_pop", level0, 0);

        // Protocol errors
        bi0.RDn = 1'b0; bi0.WRn = 1'b0;
        tick();
        bi0.RDn = 1'b1; bi0.WRn = 1'b1;
        check_eq("x_both", err0, 1);
        pulse_clr();
        check_eq("x_clr_err", err0, 0);
        bi0.ALE = 1'b1;
        {bi0.IOMn, bi0.S1, bi0.S0} = C_BAD;
        tick();
        bi0.ALE = 1'b0;
        check_eq("x_bad_code", err0, 1);
        check_eq("x_bad_level", level0, 0);
        pulse_clr();
        bi0.ALE = 1'b1;
        {bi0.IOMn, bi0.S1, bi0.S0} = C_MEMRD;
        bi0.addr = 16'h02FF;
        tick();
        bi0.ALE = 1'b0; bi0.RDn = 1'b0;
        tick();
        bi0.ALE = 1'b1; bi0.RDn = 1'b1;
        {bi0.IOMn, bi0.S1, bi0.S0} = C_FETCH;
        bi0.addr = 16'h0300;
        tick();
        bi0.ALE = 1'b0; bi0.RDn = 1'b0; bi0.data = 8'h77;
        tick();
        bi0.RDn = 1'b1; bi0.data = 8'h00;
        tick();
        check_eq("a_err", err0, 1);
        check_eq("a_level", level0, 1);
        check_eq("a_type", bi0.tr_type, 0);
        check_eq("a_addr", bi0.tr_addr, 16'h0300);
        check_eq("a_data", bi0.tr_data, 8'h77);
        cs0 = 3'd1; #1;
        check_eq("a_cnt_rd", cnt0, 0);
        pulse_clr();
        cs0 = 3'd0; #1;
        check_eq("a_clr_err", err0, 0);
        check_eq("a_clr_lvl", level0, 0);
        check_eq("a_clr_cnt", cnt0, 0);

        // en dropped mid-strobe abandons the cycle
        bi0.ALE = 1'b1;
        {bi0.IOMn, bi0.S1, bi0.S0} = C_MEMRD;
        tick();
        bi0.ALE = 1'b0; bi0.RDn = 1'b0;
        tick();
        en = 1'b0;
        tick();
        en = 1'b1; bi0.RDn = 1'b1;
        tick();
        tick();
        check_eq("en_level", level0, 0);

        // Reset mid-strobe
        for (int i = 1; i <= 17; i++) bus_cycle(C_MEMRD, 16'h0500 + 16'(i), 8'(i), 1, 1'b0);
        check_eq("r_pre_ovf", ovf0, 1);
        bi0.ALE = 1'b1;
        {bi0.IOMn, bi0.S1, bi0.S0} = C_MEMRD;
        tick();
        bi0.ALE = 1'b0; bi0.RDn = 1'b0;
        tick();
        #2 rstn = 1'b0;
        #1;
        check_eq("r_valid", bi0.tr_valid, 0);
        check_eq("r_level", level0, 0);
        check_eq("r_ovf", ovf0, 0);
        tick();
        rstn = 1'b1;
        bi0.RDn = 1'b1;
        tick();
        tick();
        check_eq("r_no_rec", level0, 0);

        // Counter saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) bus_cycle(C_FETCH, 16'h0600, 8'h00, 1, 1'b0);
        cs0 = 3'd0; cs1 = 3'd0; #1;
        check_eq("s_cnt16", cnt0, 20);
        check_eq("s_cnt4", cnt1, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
